// File: rtl/alu_input_ctrl.sv
//============================================================================
// alu_input_ctrl : debounced key/switch front end that assembles an ALU
// operand/opcode set and hands it downstream with a valid/ready handshake.
// Optional repeat-issue on KEY[2]: define ALU_INPUT_REPEAT_EN.
// Revision: 1.0
//============================================================================
`default_nettype none

module alu_input_ctrl #(
    parameter int DB_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] porta,
    output logic [31:0] portb,
    output logic [3:0]  ALUOP,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  stage
);

    localparam int c_CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GOT_A = 2'd1,
        S_GOT_B = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_key_s1, r_key_s2;
    logic [16:0] r_sw_s1, r_sw_s2;
    logic [3:0]  w_press;
    logic [31:0] w_operand;
    logic        w_win_abort, w_win_k1, w_win_k0;
    logic        w_unused_sw17;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '1;
            r_sw_s2  <= '1;
        end else begin
            r_key_s1 <= KEY;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= SW[16:0];
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_unused_sw17 = SW[17];

    // Per-key debounce; a pulse is emitted only when the accepted level falls.
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_lvl;
        logic               r_pls;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_cnt <= '0;
                r_lvl <= 1'b1;
                r_pls <= 1'b0;
            end else begin
                r_pls <= 1'b0;
                if (r_key_s2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt <= '0;
                    r_lvl <= r_key_s2[gi];
                    r_pls <= r_lvl;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_pls;
    end

    assign w_operand   = {{15{r_sw_s2[16]}}, r_sw_s2};
    assign w_win_abort = w_press[3];

`ifdef ALU_INPUT_REPEAT_EN
    logic w_win_rep;
    logic r_done;

    assign w_win_rep = w_press[2] & ~w_press[3];
    assign w_win_k1  = w_press[1] & ~w_press[3] & ~w_press[2];
    assign w_win_k0  = w_press[0] & ~w_press[3] & ~w_press[2] & ~w_press[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_done <= 1'b0;
        else if (r_state == S_ISSUE && op_valid && op_ready)
            r_done <= 1'b1;
    end
`else
    logic w_unused_key2;

    assign w_unused_key2 = w_press[2];
    assign w_win_k1      = w_press[1] & ~w_press[3];
    assign w_win_k0      = w_press[0] & ~w_press[3] & ~w_press[1];
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            porta    <= '0;
            portb    <= '0;
            ALUOP    <= '0;
            op_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_abort) begin
                        r_state <= S_IDLE;
`ifdef ALU_INPUT_REPEAT_EN
                    end else if (w_win_rep) begin
                        if (r_done) begin
                            r_state  <= S_ISSUE;
                            op_valid <= 1'b1;
                        end
`endif
                    end else if (w_win_k0) begin
                        porta   <= w_operand;
                        r_state <= S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (w_win_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_win_k0) begin
                        portb   <= w_operand;
                        r_state <= S_GOT_B;
                    end
                end
                S_GOT_B: begin
                    if (w_win_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_win_k1) begin
                        ALUOP    <= r_sw_s2[3:0];
                        op_valid <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Held until accepted; abort has no effect here.
                    if (op_valid && op_ready) begin
                        op_valid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    op_valid <= 1'b0;
                end
            endcase
        end
    end

    assign stage = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_input_ctrl.sv
//============================================================================
// tb_alu_input_ctrl : directed self-checking bench for alu_input_ctrl.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_alu_input_ctrl;

    logic        CLK;
    logic        nRST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [3:0]  ALUOP;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  stage;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;

    alu_input_ctrl #(.DB_CYCLES(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .KEY      (KEY),
        .SW       (SW),
        .porta    (porta),
        .portb    (portb),
        .ALUOP    (ALUOP),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .stage    (stage)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (op_valid) vcnt++;
        end
    endtask

    // Press and release one key long enough for both edges to debounce.
    task automatic press(input int idx);
        vcnt = 0;
        @(negedge CLK);
        KEY[idx] = 1'b0;
        idle(12);
        KEY[idx] = 1'b1;
        idle(12);
    endtask

    initial begin
        nRST     = 1'b0;
        KEY      = 4'hF;
        SW       = '0;
        op_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_porta", porta, 32'h0);
        chk("rst_portb", portb, 32'h0);
        chk("rst_aluop", {28'h0, ALUOP}, 32'h0);
        chk("rst_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_stage", {30'h0, stage}, 32'h0);
        nRST = 1'b1;
        idle(12);
        chk("rel_stage", {30'h0, stage}, 32'h0);

        // Basic transfer with a negative operand A.
        SW = 18'h10005;
        press(0);
        chk("a_stage", {30'h0, stage}, 32'h1);
        chk("a_porta", porta, 32'hFFFF0005);
        SW = 18'h00003;
        press(0);
        chk("b_stage", {30'h0, stage}, 32'h2);
        chk("b_portb", portb, 32'h00000003);
        op_ready = 1'b1;
        SW = 18'h00002;
        press(1);
        chk("x_vcnt", vcnt, 32'd1);
        chk("x_stage", {30'h0, stage}, 32'h0);
        chk("x_aluop", {28'h0, ALUOP}, 32'h2);
        chk("x_valid", {31'h0, op_valid}, 32'h0);
        chk("x_porta", porta, 32'hFFFF0005);

`ifdef ALU_INPUT_REPEAT_EN
        op_ready = 1'b0;
        press(2);
        chk("rep_stage", {30'h0, stage}, 32'h3);
        chk("rep_valid", {31'h0, op_valid}, 32'h1);
        chk("rep_porta", porta, 32'hFFFF0005);
        chk("rep_portb", portb, 32'h00000003);
        chk("rep_aluop", {28'h0, ALUOP}, 32'h2);
        op_ready = 1'b1;
        idle(2);
        chk("rep_done", {30'h0, stage}, 32'h0);
`else
        press(2);
        chk("rep_stage", {30'h0, stage}, 32'h0);
        chk("rep_valid", {31'h0, op_valid}, 32'h0);
`endif

        // KEY[1] is not meaningful in IDLE; op_ready alone does nothing.
        press(1);
        chk("k1idle_stage", {30'h0, stage}, 32'h0);
        chk("k1idle_valid", {31'h0, op_valid}, 32'h0);

        // Bouncy press: low 2, high 1, low 10 -> a single accepted press.
        SW = 18'h00007;
        @(negedge CLK); KEY[0] = 1'b0;
        idle(2);        KEY[0] = 1'b1;
        idle(1);        KEY[0] = 1'b0;
        idle(10);       KEY[0] = 1'b1;
        idle(12);
        chk("bnc_stage", {30'h0, stage}, 32'h1);
        chk("bnc_porta", porta, 32'h00000007);
        press(3);
        chk("abortA_stage", {30'h0, stage}, 32'h0);
        chk("abortA_porta", porta, 32'h00000007);

        // Stall in ISSUE; switches and abort must not disturb it.
        op_ready = 1'b0;
        SW = 18'h1FFFF;
        press(0);
        SW = 18'h0000A;
        press(0);
        SW = 18'h00005;
        press(1);
        chk("iss_stage", {30'h0, stage}, 32'h3);
        idle(20);
        SW = 18'h0F0F0;
        press(3);
        chk("stall_valid", {31'h0, op_valid}, 32'h1);
        chk("stall_stage", {30'h0, stage}, 32'h3);
        chk("stall_porta", porta, 32'hFFFFFFFF);
        chk("stall_portb", portb, 32'h0000000A);
        chk("stall_aluop", {28'h0, ALUOP}, 32'h5);

        // Asynchronous reset in the middle of a clock low phase.
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("arst_valid", {31'h0, op_valid}, 32'h0);
        chk("arst_porta", porta, 32'h0);
        chk("arst_portb", portb, 32'h0);
        chk("arst_aluop", {28'h0, ALUOP}, 32'h0);
        chk("arst_stage", {30'h0, stage}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        idle(12);
        chk("arel_stage", {30'h0, stage}, 32'h0);

        // Simultaneous KEY[1] and KEY[3] in GOT_B: abort wins.
        SW = 18'h00011;
        press(0);
        press(0);
        chk("sim_pre", {30'h0, stage}, 32'h2);
        SW = 18'h00009;
        @(negedge CLK);
        KEY = 4'b0101;
        idle(12);
        KEY = 4'hF;
        idle(12);
        chk("sim_stage", {30'h0, stage}, 32'h0);
        chk("sim_aluop", {28'h0, ALUOP}, 32'h0);
        chk("sim_valid", {31'h0, op_valid}, 32'h0);
        chk("sim_portb", portb, 32'h00000011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000: consecutive stable synchronized samples required to accept a key level change.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port KEY  input  4  raw pushbuttons, active-low, asynchronous to CLK.
REQ-005 SHALL have port SW  input  18  raw switches, quasi-static.
REQ-006 SHALL have port porta  output  32  operand A register.
REQ-007 SHALL have port portb  output  32  operand B register.
REQ-008 SHALL have port ALUOP  output  4  opcode register.
REQ-009 SHALL have port op_valid  output  1  operand/opcode set valid to downstream ALU stage.
REQ-010 SHALL have port op_ready  input  1  downstream accepts set when high with op_valid.
REQ-011 SHALL have port stage  output  2  FSM state encoding, for LEDG.

Function
REQ-012 SHALL pass each KEY bit and SW through a 2-flop synchronizer before use.
REQ-013 SHALL debounce each key with its own counter: debounced level changes only after DB_CYCLES consecutive equal synchronized samples differing from it; counter clears on any mismatch.
REQ-014 SHALL generate a one-cycle press pulse per key on debounced high-to-low transition; holding a key generates exactly one pulse.
REQ-015 SHALL form the operand value as sign-extension of synchronized SW[16:0] to 32 bits; opcode value as synchronized SW[3:0].
REQ-016 SHALL implement FSM IDLE(0), GOT_A(1), GOT_B(2), ISSUE(3), driven on stage.
REQ-017 IDLE: KEY[0] press loads porta, goes GOT_A.
REQ-018 GOT_A: KEY[0] press loads portb, goes GOT_B.
REQ-019 GOT_B: KEY[1] press loads ALUOP, goes ISSUE; op_valid rises the cycle after the press pulse.
REQ-020 ISSUE: op_valid held high and porta/portb/ALUOP held stable until op_valid&&op_ready; that cycle returns to IDLE, op_valid low next cycle.
REQ-021 KEY[3] press (abort) in IDLE/GOT_A/GOT_B SHALL return to IDLE without altering registers; in ISSUE SHALL be ignored.
REQ-022 Simultaneous press pulses SHALL resolve KEY[3] > KEY[1] > KEY[0]; only the winner acts, losers discarded.
REQ-023 Presses of keys not valid in the current state SHALL be ignored.
REQ-024 op_ready while op_valid low SHALL have no effect.

Reset
REQ-025 nRST low SHALL asynchronously force porta=0, portb=0, ALUOP=0, op_valid=0, stage=IDLE, synchronizers and debounced levels to 1 (released), counters 0.
REQ-026 Reset mid-ISSUE SHALL drop op_valid immediately without waiting for op_ready; no press pulse on reset release.

Configuration
REQ-027 Macro ALU_INPUT_REPEAT_EN defined: KEY[2] press in IDLE, after at least one completed transfer since reset, goes directly to ISSUE reusing held porta/portb/ALUOP; priority KEY[3] > KEY[2] > KEY[1] > KEY[0].
REQ-028 Macro undefined: KEY[2] SHALL be ignored in all states; no repeat-tracking logic synthesized.

Verification (DB_CYCLES=4)
REQ-029 SW=0x10005, press KEY[0]; SW=0x00003, press KEY[0]; SW=0x00002, press KEY[1]; op_ready=1 -> porta=0xFFFF0005, portb=0x00000003, ALUOP=2, op_valid one cycle, stage 0->1->2->3->0.
REQ-030 KEY[0] bounces (low 2 cycles, high 1, low 10) -> exactly one press pulse, porta loaded once.
REQ-031 In ISSUE with op_ready=0 for 20 cycles, toggle SW, press KEY[3] -> op_valid stays 1, outputs unchanged, stage=3.
REQ-032 In GOT_B, KEY[1] and KEY[3] released-debounced on same cycle -> abort wins, stage=0, ALUOP unchanged.
REQ-033 Assert nRST low mid-ISSUE between clock edges -> op_valid and all outputs 0 before next CLK edge.
REQ-034 With ALU_INPUT_REPEAT_EN after REQ-029 transfer, press KEY[2] -> stage=3, same operands, op_valid high; without macro -> stage stays 0.
